// File: rtl/gb_out_stream_checker.sv
// Passive in-order comparator for the ILA and HLS arg_0 output streams of the Gaussian-blur wrapper.
// Each side is buffered separately; a pair is popped only when both FIFOs hold data.
module gb_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [PTR_W:0]    level_o,
    output logic              drop_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              full;
    logic              accept;

    // A pop on the same edge frees the slot, so a push at full is still taken.
    assign full    = (level_q == (PTR_W+1)'(DEPTH));
    assign accept  = push_i && (!full || pop_i);
    assign drop_o  = push_i && full && !pop_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({accept, pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module gb_out_stream_checker #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4,
    parameter int EXP_BEATS = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ila_tvalid_i,
    input  logic              ila_tready_i,
    input  logic [DATA_W-1:0] ila_tdata_i,
    input  logic              hls_tvalid_i,
    input  logic              hls_tready_i,
    input  logic [DATA_W-1:0] hls_tdata_i,
    output logic [1:0]        state_o,
    output logic [15:0]       match_cnt_o,
    output logic              mismatch_o,
    output logic              overflow_o,
    output logic              extra_o,
    output logic [15:0]       err_idx_o,
    output logic [DATA_W-1:0] err_ila_data_o,
    output logic [DATA_W-1:0] err_hls_data_o,
    output logic [PTR_W:0]    ila_level_o,
    output logic [PTR_W:0]    hls_level_o
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       match_cnt_q, match_cnt_d;
    logic              mismatch_q, mismatch_d;
    logic              overflow_q, overflow_d;
    logic              extra_q, extra_d;
    logic [15:0]       err_idx_q, err_idx_d;
    logic [DATA_W-1:0] err_ila_q, err_ila_d;
    logic [DATA_W-1:0] err_hls_q, err_hls_d;
    logic [15:0]       pair_idx_q, pair_idx_d;

    logic              beat_ila, beat_hls, pop;
    logic [DATA_W-1:0] ila_head, hls_head;
    logic [PTR_W:0]    ila_level, hls_level;
    logic              ila_drop, hls_drop;

    assign beat_ila = ila_tvalid_i && ila_tready_i;
    assign beat_hls = hls_tvalid_i && hls_tready_i;
    assign pop      = (ila_level != '0) && (hls_level != '0);

    gb_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ila_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (beat_ila),
        .pop_i   (pop),
        .data_i  (ila_tdata_i),
        .head_o  (ila_head),
        .level_o (ila_level),
        .drop_o  (ila_drop)
    );

    gb_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_hls_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (beat_hls),
        .pop_i   (pop),
        .data_i  (hls_tdata_i),
        .head_o  (hls_head),
        .level_o (hls_level),
        .drop_o  (hls_drop)
    );

    always_comb begin
        match_cnt_d = match_cnt_q;
        mismatch_d  = mismatch_q;
        err_idx_d   = err_idx_q;
        err_ila_d   = err_ila_q;
        err_hls_d   = err_hls_q;
        pair_idx_d  = pair_idx_q;
        overflow_d  = overflow_q || ila_drop || hls_drop;
        extra_d     = extra_q || ((state_q == ST_PASS) && (beat_ila || beat_hls));
        if (pop) begin
            pair_idx_d = pair_idx_q + 16'd1;
            if (ila_head == hls_head) begin
                if (match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
            end else begin
                if (!mismatch_q) begin
                    err_idx_d = pair_idx_q;
                    err_ila_d = ila_head;
                    err_hls_d = hls_head;
                end
                mismatch_d = 1'b1;
            end
        end
    end

    // PASS is judged on registered counts, one edge after the final pop drains both sides.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mismatch_d || overflow_d) begin
                    state_d = ST_FAIL;
                end else if ((pair_idx_q == 16'(EXP_BEATS)) && (ila_level == '0) &&
                             (hls_level == '0) && !mismatch_q && !overflow_q) begin
                    state_d = ST_PASS;
                end
            end
            ST_PASS: if (beat_ila || beat_hls) state_d = ST_FAIL;
            default: state_d = ST_FAIL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            match_cnt_q <= '0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            extra_q     <= 1'b0;
            err_idx_q   <= '0;
            err_ila_q   <= '0;
            err_hls_q   <= '0;
            pair_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            extra_q     <= extra_d;
            err_idx_q   <= err_idx_d;
            err_ila_q   <= err_ila_d;
            err_hls_q   <= err_hls_d;
            pair_idx_q  <= pair_idx_d;
        end
    end

    assign state_o        = state_q;
    assign match_cnt_o    = match_cnt_q;
    assign mismatch_o     = mismatch_q;
    assign overflow_o     = overflow_q;
    assign extra_o        = extra_q;
    assign err_idx_o      = err_idx_q;
    assign err_ila_data_o = err_ila_q;
    assign err_hls_data_o = err_hls_q;
    assign ila_level_o    = ila_level;
    assign hls_level_o    = hls_level;
endmodule

// File: tb/tb_gb_out_stream_checker.sv
// Bench for gb_out_stream_checker: directed scenarios plus randomized runs against a queue-based model.
module tb_gb_out_stream_checker;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int PTR_W     = 4;
    localparam int EXP_BEATS = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ila_tvalid_i, ila_tready_i, hls_tvalid_i, hls_tready_i;
    logic [DATA_W-1:0] ila_tdata_i, hls_tdata_i;
    logic [1:0]        state_o;
    logic [15:0]       match_cnt_o, err_idx_o;
    logic              mismatch_o, overflow_o, extra_o;
    logic [DATA_W-1:0] err_ila_data_o, err_hls_data_o;
    logic [PTR_W:0]    ila_level_o, hls_level_o;

    always #5 clk_i = ~clk_i;

    gb_out_stream_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .EXP_BEATS(EXP_BEATS)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ila_tvalid_i   (ila_tvalid_i),
        .ila_tready_i   (ila_tready_i),
        .ila_tdata_i    (ila_tdata_i),
        .hls_tvalid_i   (hls_tvalid_i),
        .hls_tready_i   (hls_tready_i),
        .hls_tdata_i    (hls_tdata_i),
        .state_o        (state_o),
        .match_cnt_o    (match_cnt_o),
        .mismatch_o     (mismatch_o),
        .overflow_o     (overflow_o),
        .extra_o        (extra_o),
        .err_idx_o      (err_idx_o),
        .err_ila_data_o (err_ila_data_o),
        .err_hls_data_o (err_hls_data_o),
        .ila_level_o    (ila_level_o),
        .hls_level_o    (hls_level_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dut_max_ila = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: two queues and the outcome flags, updated once per rising edge.
    logic [7:0]  m_ila[$];
    logic [7:0]  m_hls[$];
    logic [1:0]  m_state;
    logic [15:0] m_match, m_pairs, m_err_idx;
    logic        m_mis, m_ovf, m_extra;
    logic [7:0]  m_err_ila, m_err_hls;

    task automatic model_step(input bit r, input bit bi, input logic [7:0] di,
                              input bit bh, input logic [7:0] dh);
        int         li, lh;
        bit         pop, done;
        logic [7:0] a, b;
        if (r) begin
            m_ila.delete();
            m_hls.delete();
            m_state = 2'd0; m_match = '0; m_pairs = '0; m_err_idx = '0;
            m_mis = 1'b0; m_ovf = 1'b0; m_extra = 1'b0; m_err_ila = '0; m_err_hls = '0;
            return;
        end
        li   = m_ila.size();
        lh   = m_hls.size();
        pop  = (li > 0) && (lh > 0);
        done = (m_pairs == 16'(EXP_BEATS)) && (li == 0) && (lh == 0) && !m_mis && !m_ovf;
        if (m_state == 2'd1 && (bi || bh)) m_extra = 1'b1;
        if (pop) begin
            a = m_ila.pop_front();
            b = m_hls.pop_front();
            if (a == b) begin
                if (m_match != 16'hFFFF) m_match = m_match + 16'd1;
            end else begin
                if (!m_mis) begin
                    m_err_idx = m_pairs;
                    m_err_ila = a;
                    m_err_hls = b;
                end
                m_mis = 1'b1;
            end
            m_pairs = m_pairs + 16'd1;
        end
        if (bi) begin
            if (li < DEPTH || pop) m_ila.push_back(di);
            else m_ovf = 1'b1;
        end
        if (bh) begin
            if (lh < DEPTH || pop) m_hls.push_back(dh);
            else m_ovf = 1'b1;
        end
        case (m_state)
            2'd0: begin
                if (m_mis || m_ovf) m_state = 2'd2;
                else if (done) m_state = 2'd1;
            end
            2'd1: if (bi || bh) m_state = 2'd2;
            default: m_state = 2'd2;
        endcase
    endtask

    task automatic check_all();
        check_val("state", state_o, m_state);
        check_val("match_cnt", match_cnt_o, m_match);
        check_val("mismatch", mismatch_o, m_mis);
        check_val("overflow", overflow_o, m_ovf);
        check_val("extra", extra_o, m_extra);
        check_val("err_idx", err_idx_o, m_err_idx);
        check_val("err_ila", err_ila_data_o, m_err_ila);
        check_val("err_hls", err_hls_data_o, m_err_hls);
        check_val("ila_level", ila_level_o, m_ila.size());
        check_val("hls_level", hls_level_o, m_hls.size());
        if (int'(ila_level_o) > dut_max_ila) dut_max_ila = int'(ila_level_o);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic cyc(input bit r, input bit iv, input bit ir, input logic [7:0] id,
                       input bit hv, input bit hr, input logic [7:0] hd);
        rst_i = r;
        ila_tvalid_i = iv; ila_tready_i = ir; ila_tdata_i = id;
        hls_tvalid_i = hv; hls_tready_i = hr; hls_tdata_i = hd;
        @(posedge clk_i);
        model_step(r, iv && ir, id, hv && hr, hd);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic beat(input bit iv, input logic [7:0] id, input bit hv, input logic [7:0] hd);
        cyc(1'b0, iv, iv ? 1'b1 : 1'($urandom_range(0, 1)), id,
            hv, hv ? 1'b1 : 1'($urandom_range(0, 1)), hd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) beat(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] ila_d [4];
        logic [7:0] hls_d [4];
        logic [7:0] seq [6];
        rst_i = 1'b1;
        ila_tvalid_i = 1'b0; ila_tready_i = 1'b0; ila_tdata_i = '0;
        hls_tvalid_i = 1'b0; hls_tready_i = 1'b0; hls_tdata_i = '0;
        model_step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk_i);
        do_reset();
        check_val("rst_state", state_o, 0);

        // Clean run, HLS lagging ILA by two cycles, then one extra HLS beat.
        dut_max_ila = 0;
        beat(1, 8'd1, 0, 8'd0);
        beat(1, 8'd2, 0, 8'd0);
        beat(1, 8'd3, 1, 8'd1);
        beat(1, 8'd4, 1, 8'd2);
        beat(0, 8'd0, 1, 8'd3);
        beat(0, 8'd0, 1, 8'd4);
        idle(3);
        check_val("s1_state_pass", state_o, 1);
        check_val("s1_match4", match_cnt_o, 4);
        check_val("s1_max_ila_level", dut_max_ila, 3);
        beat(0, 8'd0, 1, 8'h77);
        check_val("s1_extra", extra_o, 1);
        check_val("s1_state_fail", state_o, 2);

        // First mismatch at pair 2 is held; pair 3 also differs.
        do_reset();
        ila_d = '{8'h10, 8'h11, 8'h55, 8'h13};
        hls_d = '{8'h10, 8'h11, 8'hAA, 8'h99};
        for (int k = 0; k < 4; k++) beat(1, ila_d[k], 1, hls_d[k]);
        idle(3);
        check_val("s2_err_idx", err_idx_o, 2);
        check_val("s2_err_ila", err_ila_data_o, 8'h55);
        check_val("s2_err_hls", err_hls_data_o, 8'hAA);
        check_val("s2_state", state_o, 2);

        // Seventeen ILA beats into a silent HLS side; the last is dropped.
        do_reset();
        for (int k = 0; k < 17; k++) beat(1, 8'(k), 0, 8'h00);
        check_val("s3_ila_level", ila_level_o, 16);
        check_val("s3_overflow", overflow_o, 1);
        check_val("s3_state", state_o, 2);
        for (int k = 0; k < 16; k++) beat(0, 8'h00, 1, 8'(k));
        idle(2);
        check_val("s3_match16", match_cnt_o, 16);
        check_val("s3_no_mismatch", mismatch_o, 0);

        // Full ILA FIFO: a push on the same edge as a pop is accepted.
        do_reset();
        for (int k = 0; k < 16; k++) beat(1, 8'(k), 0, 8'h00);
        beat(0, 8'h00, 1, 8'h00);
        beat(1, 8'd16, 0, 8'h00);
        check_val("s4_ila_level", ila_level_o, 16);
        check_val("s4_no_overflow", overflow_o, 0);
        idle(2);

        // Mid-run reset with buffered beats, a set mismatch and a valid ILA beat.
        do_reset();
        beat(1, 8'd0, 1, 8'hF0);
        beat(1, 8'd1, 1, 8'hF1);
        for (int k = 2; k < 8; k++) beat(1, 8'(k), 0, 8'h00);
        check_val("s6_mis_before", mismatch_o, 1);
        cyc(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
        check_val("s6_state", state_o, 0);
        check_val("s6_ila_level", ila_level_o, 0);
        check_val("s6_mismatch", mismatch_o, 0);
        check_val("s6_err_idx", err_idx_o, 0);

        // Randomized runs: varying beat counts, gaps, ready stalls and occasional corruption.
        for (int run = 0; run < 16; run++) begin
            int n_i, n_h, p_i, p_h;
            bit iv, ir, hv, hr;
            do_reset();
            for (int k = 0; k < 6; k++) seq[k] = 8'($urandom);
            n_i = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : 4;
            n_h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : 4;
            p_i = 0;
            p_h = 0;
            for (int c = 0; c < 40; c++) begin
                logic [7:0] dh;
                iv = (p_i < n_i) && ($urandom_range(0, 1) == 1);
                hv = (p_h < n_h) && ($urandom_range(0, 1) == 1);
                ir = ($urandom_range(0, 3) != 0);
                hr = ($urandom_range(0, 3) != 0);
                dh = (p_h < 6) ? seq[p_h] : 8'h00;
                if ($urandom_range(0, 11) == 0) dh = dh ^ 8'h01;
                cyc(1'b0, iv, ir, (p_i < 6) ? seq[p_i] : 8'h00, hv, hr, dh);
                if (iv && ir) p_i++;
                if (hv && hr) p_h++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
